instr_fetch_unit: RTL and testbench

- Instruction-fetch front end that feeds the cpu datapath/decoder.
- After a `start` pulse it walks a PC through a synchronous instruction ROM with 1-cycle read latency.
- Presents each word to the downstream decode stage over a valid/ready handshake.
- Accepts branch redirects from execute, and halt detection is available as a compile-time option.

---
 rtl/instr_fetch_unit.sv | 212 +++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction-fetch front end. After a start pulse it walks a program
//   counter through a synchronous instruction ROM (1-cycle read latency) and
//   hands every fetched word to the decode stage over a valid/ready handshake.
//   Branch redirects from execute reload the PC. A start pulse while busy
//   restarts fetching at START_ADDR.
//
//   Per instruction the FSM walks FETCH (ROM read issued) -> WAIT (ROM data
//   captured) -> HOLD (word presented). This gives 1 instruction per 3 clocks
//   with out_ready held high.
//
// Optional feature (compile-time macro FETCH_HALT_DETECT_EN):
//   When defined, a fetched word equal to HALT_WORD is delivered normally.
//   Once it is accepted, the unit parks in HALTED instead of fetching on.
//   When undefined, HALT_WORD is an ordinary instruction and HALTED is never
//   entered.
//
// Parameters:
//   AW         PC / instruction-memory address width
//   DW         instruction word width
//   START_ADDR PC loaded on start
//   HALT_WORD  opcode that terminates fetching (halt-detect builds only)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset, highest priority
//   start         in   one-cycle pulse, (re)launch fetch at START_ADDR
//   branch_valid  in   redirect request from execute
//   branch_target in   redirect PC, used when branch_valid=1
//   mem_en        out  ROM read enable
//   mem_addr      out  ROM read address (0 when no read is issued)
//   mem_rdata     in   ROM data, valid the cycle after mem_en=1
//   out_valid     out  out_instr/out_pc hold a fetched instruction
//   out_ready     in   downstream accepts when out_valid & out_ready
//   out_instr     out  fetched instruction word
//   out_pc        out  address of out_instr
//   busy          out  high in FETCH, WAIT or HOLD
//   halted        out  high in HALTED
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                AW         = 8,
   parameter int                DW         = 16,
   parameter logic [AW-1:0]     START_ADDR = '0,
   parameter logic [DW-1:0]     HALT_WORD  = DW'(16'hFFFF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          branch_valid,
   input  logic [AW-1:0] branch_target,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_instr,
   output logic [AW-1:0] out_pc,
   output logic          busy,
   output logic          halted
);

   // Halt detection is folded into a constant so that the default build keeps
   // the same datapath; with the constant at 0 the halt flag can never be set
   // and the HALTED state is unreachable.
`ifdef FETCH_HALT_DETECT_EN
   localparam logic HALT_EN = 1'b1;
`else
   localparam logic HALT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_HOLD   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t        state_reg,        state_next;
   logic [AW-1:0] pc_reg,           pc_next;
   logic          out_valid_reg,    out_valid_next;
   logic [DW-1:0] out_instr_reg,    out_instr_next;
   logic [AW-1:0] out_pc_reg,       out_pc_next;
   logic          halt_pending_reg, halt_pending_next;

   logic          busy_state;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          halt_hit;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_IDLE;
         pc_reg           <= START_ADDR;
         out_valid_reg    <= 1'b0;
         out_instr_reg    <= '0;
         out_pc_reg       <= '0;
         halt_pending_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         out_valid_reg    <= out_valid_next;
         out_instr_reg    <= out_instr_next;
         out_pc_reg       <= out_pc_next;
         halt_pending_reg <= halt_pending_next;
      end
   end

   // -------------------------------------------------------------------------
   // Redirect decode. start outranks branch_valid, and both only act while a
   // fetch is in progress; IDLE and HALTED handle start themselves.
   // -------------------------------------------------------------------------
   assign busy_state  = (state_reg == S_FETCH) ||
                        (state_reg == S_WAIT)  ||
                        (state_reg == S_HOLD);
   assign redirect    = busy_state && (start || branch_valid);
   assign redirect_pc = start ? START_ADDR : branch_target;
   assign halt_hit    = HALT_EN && (mem_rdata == HALT_WORD);

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      out_valid_next    = out_valid_reg;
      out_instr_next    = out_instr_reg;
      out_pc_next       = out_pc_reg;
      halt_pending_next = halt_pending_reg;

      case (state_reg)
         S_IDLE, S_HALTED: begin
            // branch_valid has no meaning until fetching has been launched.
            if (start) begin
               state_next        = S_FETCH;
               pc_next           = START_ADDR;
               out_valid_next    = 1'b0;
               halt_pending_next = 1'b0;
            end
         end

         S_FETCH: begin
            if (redirect) begin
               state_next        = S_FETCH;
               pc_next           = redirect_pc;
               out_valid_next    = 1'b0;
               halt_pending_next = 1'b0;
            end else begin
               state_next = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect) begin
               // The ROM word arriving this cycle belongs to the old path and
               // is simply not captured.
               state_next        = S_FETCH;
               pc_next           = redirect_pc;
               out_valid_next    = 1'b0;
               halt_pending_next = 1'b0;
            end else begin
               state_next        = S_HOLD;
               out_instr_next    = mem_rdata;
               out_pc_next       = pc_reg;
               pc_next           = pc_reg + AW'(1);   // wraps modulo 2^AW
               out_valid_next    = 1'b1;
               halt_pending_next = halt_hit;
            end
         end

         S_HOLD: begin
            // With out_ready also high, the held word is transferred on this
            // edge regardless of a redirect; the redirect only decides where
            // fetching continues and drops any pending halt.
            if (redirect) begin
               state_next        = S_FETCH;
               pc_next           = redirect_pc;
               out_valid_next    = 1'b0;
               halt_pending_next = 1'b0;
            end else if (out_ready) begin
               state_next        = halt_pending_reg ? S_HALTED : S_FETCH;
               out_valid_next    = 1'b0;
               halt_pending_next = 1'b0;
            end
         end

         default: begin
            state_next        = S_IDLE;
            out_valid_next    = 1'b0;
            halt_pending_next = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs, decoded from registers only
   // -------------------------------------------------------------------------
   assign mem_en    = (state_reg == S_FETCH);
   assign mem_addr  = mem_en ? pc_reg : '0;
   assign out_valid = out_valid_reg;
   assign out_instr = out_instr_reg;
   assign out_pc    = out_pc_reg;
   assign busy      = busy_state;
   assign halted    = (state_reg == S_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        branch_valid = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic        mem_en;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_instr;
   logic [7:0]  out_pc;
   logic        busy;
   logic        halted;

   // second instance checks PC wrap from START_ADDR=FE
   logic        start_w = 1'b0;
   logic        branch_valid_w = 1'b0;
   logic [7:0]  branch_target_w = 8'h00;
   logic        mem_en_w;
   logic [7:0]  mem_addr_w;
   logic [15:0] mem_rdata_w = 16'h0000;
   logic        out_valid_w;
   logic        out_ready_w = 1'b1;
   logic [15:0] out_instr_w;
   logic [7:0]  out_pc_w;
   logic        busy_w;
   logic        halted_w;

   logic [15:0] rom [256];

   int total = 0;
   int bad = 0;
   int n_xfer = 0;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] instr;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [7:0]  target;
      logic [15:0] instr0;
      logic [15:0] instr1;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   instr_fetch_unit #(.AW(8), .DW(16), .START_ADDR(8'h00), .HALT_WORD(16'hFFFF)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .busy(busy), .halted(halted)
   );

   instr_fetch_unit #(.AW(8), .DW(16), .START_ADDR(8'hFE), .HALT_WORD(16'hFFFF)) u_dut_wrap (
      .clk(clk), .rst(rst), .start(start_w),
      .branch_valid(branch_valid_w), .branch_target(branch_target_w),
      .mem_en(mem_en_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w),
      .out_instr(out_instr_w), .out_pc(out_pc_w),
      .busy(busy_w), .halted(halted_w)
   );

   // ROM models, 1-cycle read latency
   always @(posedge clk) begin
      if (mem_en)   mem_rdata   <= rom[mem_addr];
      if (mem_en_w) mem_rdata_w <= rom[mem_addr_w];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard: a transfer is seen at the negedge before the edge that takes it.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_xfer++;
         $display("xfer #%0d pc=%02h instr=%04h", n_xfer, out_pc, out_instr);
         if (sb_q.size() == 0) begin
            check("unexpected_xfer", 32'(out_pc), 32'hDEAD);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_pc", 32'(out_pc), 32'(e.pc));
            check("sb_instr", 32'(out_instr), 32'(e.instr));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] pc, input logic [15:0] instr);
      exp_t e;
      e.pc = pc;
      e.instr = instr;
      sb_q.push_back(e);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      if (!out_valid) check(name, 32'(out_valid), 32'd1);
   endtask

   task automatic wait_xfer(input int goal, input string name);
      int n;
      n = 0;
      while (n_xfer < goal && n < 100) begin
         tick();
         n++;
      end
      if (n_xfer < goal) check(name, 32'(n_xfer), 32'(goal));
   endtask

   initial begin
      logic [7:0]  wrap_pc [4];
      logic [15:0] wrap_in [4];
      int idx;

      for (int a = 0; a < 256; a++) rom[a] = {a[7:0], ~a[7:0]};
      rom[0] = 16'h1111;
      rom[1] = 16'h2222;
      rom[2] = 16'h3333;
      rom[3] = 16'h4444;
      rom[8'h20] = 16'hFFFF;

      vecs[0] = '{8'h10, 16'h10EF, 16'h11EE};
      vecs[1] = '{8'h40, 16'h40BF, 16'h41BE};
      vecs[2] = '{8'h7F, 16'h7F80, 16'h807F};
      vecs[3] = '{8'hFF, 16'hFF00, 16'h1111};
      vecs[4] = '{8'h02, 16'h3333, 16'h4444};

      wrap_pc[0] = 8'hFE; wrap_in[0] = 16'hFE01;
      wrap_pc[1] = 8'hFF; wrap_in[1] = 16'hFF00;
      wrap_pc[2] = 8'h00; wrap_in[2] = 16'h1111;
      wrap_pc[3] = 8'h01; wrap_in[3] = 16'h2222;

      // ---------------- reset state
      tick(); tick();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_instr", 32'(out_instr), 0);
      check("rst_out_pc", 32'(out_pc), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_halted", 32'(halted), 0);
      rst = 1'b0;
      tick();

      // ---------------- start and fetch, latency and throughput
      out_ready = 1'b1;
      push(8'h00, 16'h1111);
      push(8'h01, 16'h2222);
      push(8'h02, 16'h3333);
      push(8'h03, 16'h4444);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_mem_en", 32'(mem_en), 1);
      check("start_mem_addr", 32'(mem_addr), 0);
      check("start_busy", 32'(busy), 1);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) tick();
         check($sformatf("cadence_valid_%0d", k), 32'(out_valid), 32'((k % 3) == 2));
      end
      tick();
      out_ready = 1'b0;

      // ---------------- backpressure
      wait_valid("bp_wait_valid");
      for (int k = 0; k < 5; k++) begin
         check("bp_instr", 32'(out_instr), 32'h04FB);
         check("bp_pc", 32'(out_pc), 32'h04);
         check("bp_mem_en", 32'(mem_en), 0);
         check("bp_valid", 32'(out_valid), 1);
         tick();
      end
      push(8'h04, 16'h04FB);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_one_xfer_valid", 32'(out_valid), 0);
      check("bp_next_addr", 32'(mem_addr), 32'h05);
      check("bp_next_en", 32'(mem_en), 1);

      // ---------------- table: redirect from HOLD (held word dropped)
      foreach (vecs[i]) begin
         int goal;
         wait_valid("tbl_wait_valid");
         branch_valid = 1'b1;
         branch_target = vecs[i].target;
         tick();
         branch_valid = 1'b0;
         check("tbl_redir_valid", 32'(out_valid), 0);
         check("tbl_redir_addr", 32'(mem_addr), 32'(vecs[i].target));
         push(vecs[i].target, vecs[i].instr0);
         push(vecs[i].target + 8'd1, vecs[i].instr1);
         goal = n_xfer + 2;
         out_ready = 1'b1;
         wait_xfer(goal, "tbl_xfer_timeout");
         out_ready = 1'b0;
      end

      // ---------------- redirect during WAIT
      wait_valid("rw_wait_valid");
      push(8'h04, 16'h04FB);
      out_ready = 1'b1;
      tick();
      check("rw_fetch_addr", 32'(mem_addr), 32'h05);
      tick();
      check("rw_in_wait_en", 32'(mem_en), 0);
      branch_valid = 1'b1;
      branch_target = 8'h40;
      tick();
      branch_valid = 1'b0;
      check("rw_valid", 32'(out_valid), 0);
      check("rw_addr", 32'(mem_addr), 32'h40);
      push(8'h40, 16'h40BF);
      push(8'h41, 16'h41BE);
      wait_xfer(n_xfer + 2, "rw_xfer_timeout");
      out_ready = 1'b0;

      // ---------------- reset mid-fetch (in WAIT)
      wait_valid("rm_wait_valid");
      push(8'h42, 16'h42BD);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rm_valid", 32'(out_valid), 0);
      check("rm_busy", 32'(busy), 0);
      check("rm_mem_en", 32'(mem_en), 0);
      check("rm_mem_addr", 32'(mem_addr), 0);
      out_ready = 1'b1;
      push(8'h00, 16'h1111);
      push(8'h01, 16'h2222);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rm_restart_addr", 32'(mem_addr), 0);
      wait_xfer(n_xfer + 2, "rm_xfer_timeout");
      out_ready = 1'b0;

      // ---------------- start beats branch_valid while busy
      wait_valid("sp_wait_valid");
      start = 1'b1;
      branch_valid = 1'b1;
      branch_target = 8'h10;
      tick();
      start = 1'b0;
      branch_valid = 1'b0;
      check("sp_addr", 32'(mem_addr), 0);
      check("sp_valid", 32'(out_valid), 0);
      push(8'h00, 16'h1111);
      out_ready = 1'b1;
      wait_xfer(n_xfer + 1, "sp_xfer_timeout");
      out_ready = 1'b0;

      // ---------------- branch with out_ready in HOLD: held word transferred
      wait_valid("hb_wait_valid");
      push(8'h01, 16'h2222);
      out_ready = 1'b1;
      branch_valid = 1'b1;
      branch_target = 8'h10;
      tick();
      branch_valid = 1'b0;
      check("hb_addr", 32'(mem_addr), 32'h10);
      check("hb_valid", 32'(out_valid), 0);
      push(8'h10, 16'h10EF);
      wait_xfer(n_xfer + 1, "hb_xfer_timeout");
      out_ready = 1'b0;

      // ---------------- halt word
      wait_valid("ht_wait_valid");
      branch_valid = 1'b1;
      branch_target = 8'h1E;
      tick();
      branch_valid = 1'b0;
      push(8'h1E, 16'h1EE1);
      push(8'h1F, 16'h1FE0);
      push(8'h20, 16'hFFFF);
      out_ready = 1'b1;
      wait_xfer(n_xfer + 3, "ht_xfer_timeout");
`ifdef FETCH_HALT_DETECT_EN
      out_ready = 1'b0;
      check("ht_halted", 32'(halted), 1);
      check("ht_busy", 32'(busy), 0);
      check("ht_mem_en", 32'(mem_en), 0);
      check("ht_valid", 32'(out_valid), 0);
      branch_valid = 1'b1;
      branch_target = 8'h40;
      tick();
      branch_valid = 1'b0;
      tick();
      check("ht_branch_ignored", 32'(halted), 1);
      check("ht_branch_no_fetch", 32'(mem_en), 0);
      out_ready = 1'b1;
      push(8'h00, 16'h1111);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ht_restart_halted", 32'(halted), 0);
      check("ht_restart_addr", 32'(mem_addr), 0);
      wait_xfer(n_xfer + 1, "ht_restart_timeout");
      out_ready = 1'b0;
`else
      check("nh_halted", 32'(halted), 0);
      check("nh_busy", 32'(busy), 1);
      push(8'h21, 16'h21DE);
      wait_xfer(n_xfer + 1, "nh_xfer_timeout");
      out_ready = 1'b0;
      check("nh_halted_after", 32'(halted), 0);
`endif

      // ---------------- PC wrap from START_ADDR=FE
      start_w = 1'b1;
      tick();
      start_w = 1'b0;
      idx = 0;
      for (int n = 0; n < 40 && idx < 4; n++) begin
         tick();
         if (out_valid_w) begin
            $display("wrap xfer pc=%02h instr=%04h", out_pc_w, out_instr_w);
            check("wrap_pc", 32'(out_pc_w), 32'(wrap_pc[idx]));
            check("wrap_instr", 32'(out_instr_w), 32'(wrap_in[idx]));
            idx++;
         end
      end
      check("wrap_count", 32'(idx), 4);
      out_ready_w = 1'b0;

      tick();
      check("sb_empty", 32'(sb_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
